// File: rtl/secded_pkg.sv
// secded_pkg: shared definitions for the SECDED scrubber slice.
//   - codeword / data / counter widths
//   - scrubber FSM state enum
//   - helper functions describing the (72,64) Hamming layout:
//       bit 0           overall parity
//       bits 1,2,4..64  Hamming check bits (power-of-two positions)
//       other bits      data, LSB first in ascending position order
package secded_pkg;

    localparam int CW_W   = 72;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;
    localparam int PAR_W  = 7;

    typedef enum logic [2:0] {
        IDLE,
        GAP_WAIT,
        READ,
        DECODE,
        ENCODE,
        WRITE
    } scrub_state_e;

    // Scatter data bits over the non-power-of-two positions 1..71.
    function automatic logic [CW_W-1:0] place_data(input logic [DATA_W-1:0] data);
        logic [CW_W-1:0] cw;
        logic [5:0]      d;
        cw = '0;
        d  = '0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = data[d];
                d = d + 6'd1;
            end
        end
        return cw;
    endfunction

    // Gather data bits back out of a codeword (inverse of place_data).
    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] data;
        logic [5:0]        d;
        data = '0;
        d    = '0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                data[d] = cw[pos];
                d = d + 6'd1;
            end
        end
        return data;
    endfunction

    // XOR of the position indices of every set bit in positions 1..71.
    // Zero for a clean word; equals the flipped position for a single error.
    function automatic logic [PAR_W-1:0] syndrome(input logic [CW_W-1:0] cw);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int pos = 1; pos < CW_W; pos++) begin
            if (cw[pos]) begin
                s = s ^ PAR_W'(pos);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/secded_decoder.sv
// secded_decoder: registered (72,64) SECDED decoder, one cycle of latency.
//   CLK, RST  clock and synchronous active-high reset
//   CW        in   72  codeword sampled every cycle
//   D_DATA    out  64  corrected data
//   ERR       out  1   any error detected
//   S_ERR     out  1   single (corrected) error
//   D_ERR     out  1   uncorrectable error
module secded_decoder
    import secded_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [CW_W-1:0]   CW,
    output logic [DATA_W-1:0] D_DATA,
    output logic              ERR,
    output logic              S_ERR,
    output logic              D_ERR
);

    logic [PAR_W-1:0] syn;
    logic [CW_W-1:0]  fixed;
    logic             single;
    logic             dbl;

    // Odd overall parity means an odd number of flips: a syndrome inside the
    // word names the bit to repair (zero means the parity bit itself).
    // A syndrome pointing past bit 71 can only come from a multi-bit error.
    always_comb begin
        syn    = syndrome(CW);
        fixed  = CW;
        single = 1'b0;
        dbl    = 1'b0;
        if (^CW) begin
            if (int'(syn) < CW_W) begin
                single     = 1'b1;
                fixed[syn] = ~CW[syn];
            end else begin
                dbl = 1'b1;
            end
        end else if (syn != '0) begin
            dbl = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            D_DATA <= '0;
            ERR    <= 1'b0;
            S_ERR  <= 1'b0;
            D_ERR  <= 1'b0;
        end else begin
            D_DATA <= extract_data(fixed);
            ERR    <= single | dbl;
            S_ERR  <= single;
            D_ERR  <= dbl;
        end
    end

endmodule

// File: rtl/secded_encoder.sv
// secded_encoder: combinational (72,64) SECDED encoder.
//   DATA    in   64  data word
//   E_DATA  out  72  codeword (layout in secded_pkg)
module secded_encoder
    import secded_pkg::*;
(
    input  logic [DATA_W-1:0] DATA,
    output logic [CW_W-1:0]   E_DATA
);

    logic [CW_W-1:0]  cw;
    logic [PAR_W-1:0] syn;

    // With the check positions still zero, the syndrome of the data-only word
    // is exactly the set of check bits that makes the full syndrome zero.
    always_comb begin
        cw  = place_data(DATA);
        syn = syndrome(cw);
        for (int k = 0; k < PAR_W; k++) begin
            cw[1 << k] = syn[k];
        end
        cw[0]  = ^cw[CW_W-1:1];
        E_DATA = cw;
    end

endmodule

// File: rtl/secded_scrubber.sv
// secded_scrubber: background memory scrubber. Walks every word, decodes it,
// writes back corrected single-bit errors and logs uncorrectable ones.
//   CLK, RST           clock, synchronous active-high reset
//   EN                 scrub enable (no new read starts while low)
//   HOST_BUSY          host owns the memory port; no strobes this cycle
//   MEM_RE / MEM_WE    one-cycle read / write strobes, MEM_ADDR shared
//   MEM_WDATA          re-encoded codeword for writeback
//   MEM_RDATA          codeword, valid the cycle after MEM_RE
//   CE_CNT / UE_CNT    saturating corrected / uncorrectable counters
//   UE_FLAG, UE_ADDR   sticky uncorrectable flag and its latest address
//   UE_CLR             clears UE_FLAG only
//   PASS_DONE          pulse in the cycle the pointer wraps to 0
module secded_scrubber
    import secded_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int GAP    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              HOST_BUSY,
    output logic              MEM_RE,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [CW_W-1:0]   MEM_WDATA,
    input  logic [CW_W-1:0]   MEM_RDATA,
    output logic [CNT_W-1:0]  CE_CNT,
    output logic [CNT_W-1:0]  UE_CNT,
    output logic              UE_FLAG,
    output logic [ADDR_W-1:0] UE_ADDR,
    input  logic              UE_CLR,
    output logic              PASS_DONE
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    scrub_state_e      state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              dwait_q, dwait_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CW_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]  ce_q, ce_d, ue_q, ue_d;
    logic              ueFlag_q, ueFlag_d;
    logic [ADDR_W-1:0] ueAddr_q, ueAddr_d;

    logic              readStb, writeStb, advance, ueSet;
    logic [DATA_W-1:0] decData;
    logic              decErr, decSErr, decDErr;
    logic [CW_W-1:0]   encData;

    secded_decoder u_dec (
        .CLK    (CLK),
        .RST    (RST),
        .CW     (MEM_RDATA),
        .D_DATA (decData),
        .ERR    (decErr),
        .S_ERR  (decSErr),
        .D_ERR  (decDErr)
    );

    secded_encoder u_enc (
        .DATA   (data_q),
        .E_DATA (encData)
    );

    // Next-state logic. DECODE spends one cycle while the read data lands in
    // the decoder register and acts on the decoder result in the second.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gap_d    = gap_q;
        dwait_d  = dwait_q;
        data_d   = data_q;
        wdata_d  = wdata_q;
        ce_d     = ce_q;
        ue_d     = ue_q;
        ueAddr_d = ueAddr_q;
        ueSet    = 1'b0;
        readStb  = 1'b0;
        writeStb = 1'b0;
        advance  = 1'b0;
        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (EN) state_d = GAP_WAIT;
            end
            GAP_WAIT: begin
                if (!EN) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else if (int'(gap_q) >= GAP - 1) begin
                    state_d = READ;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            READ: begin
                if (!EN) begin
                    state_d = IDLE;
                end else if (!HOST_BUSY) begin
                    readStb = 1'b1;
                    dwait_d = 1'b0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (!dwait_q) begin
                    dwait_d = 1'b1;
                end else begin
                    dwait_d = 1'b0;
                    if (decErr && decSErr) begin
                        if (ce_q != '1) ce_d = ce_q + CNT_W'(1);
                        data_d  = decData;
                        state_d = ENCODE;
                    end else begin
                        if (decErr && decDErr) begin
                            if (ue_q != '1) ue_d = ue_q + CNT_W'(1);
                            ueSet    = 1'b1;
                            ueAddr_d = ptr_q;
                        end
                        advance = 1'b1;
                    end
                end
            end
            ENCODE: begin
                wdata_d = encData;
                state_d = WRITE;
            end
            WRITE: begin
                if (!HOST_BUSY) begin
                    writeStb = 1'b1;
                    advance  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (advance) begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = EN ? GAP_WAIT : IDLE;
        end
        // A new uncorrectable error beats a simultaneous clear.
        ueFlag_d = ueSet ? 1'b1 : (UE_CLR ? 1'b0 : ueFlag_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gap_q    <= '0;
            dwait_q  <= 1'b0;
            data_q   <= '0;
            wdata_q  <= '0;
            ce_q     <= '0;
            ue_q     <= '0;
            ueFlag_q <= 1'b0;
            ueAddr_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gap_q    <= gap_d;
            dwait_q  <= dwait_d;
            data_q   <= data_d;
            wdata_q  <= wdata_d;
            ce_q     <= ce_d;
            ue_q     <= ue_d;
            ueFlag_q <= ueFlag_d;
            ueAddr_q <= ueAddr_d;
        end
    end

    // Strobes are masked by RST so a reset landing in READ/WRITE never
    // lets an access escape in the reset cycle itself.
    assign MEM_RE    = readStb & ~RST;
    assign MEM_WE    = writeStb & ~RST;
    assign PASS_DONE = advance & (ptr_q == '1) & ~RST;
    assign MEM_ADDR  = ptr_q;
    assign MEM_WDATA = wdata_q;
    assign CE_CNT    = ce_q;
    assign UE_CNT    = ue_q;
    assign UE_FLAG   = ueFlag_q;
    assign UE_ADDR   = ueAddr_q;

endmodule

// File: tb/tb_secded_scrubber.sv
// tb_secded_scrubber: directed self-checking bench for secded_scrubber with
// ADDR_W=2, GAP=2. A behavioural memory answers reads one cycle after MEM_RE
// and reloads its image while RST is high. Cycle numbers below are relative
// to the first cycle after reset release with EN=1 (that cycle is IDLE).
module tb_secded_scrubber;

    localparam int ADDR_W = 2;
    localparam int GAP    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              CLK = 1'b0;
    logic              RST, EN, HOST_BUSY, UE_CLR;
    logic              MEM_RE, MEM_WE, UE_FLAG, PASS_DONE;
    logic [ADDR_W-1:0] MEM_ADDR, UE_ADDR;
    logic [71:0]       MEM_WDATA, MEM_RDATA;
    logic [15:0]       CE_CNT, UE_CNT;

    logic [71:0] image [DEPTH];
    logic [71:0] mem   [DEPTH];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int rdAddr[$], rdCyc[$], wrAddr[$], wrCyc[$];
    logic [71:0] wrData[$];
    int passCnt = 0, passAddr = -1, badStrobe = 0, flagSeen = 0;

    always #5 CLK = ~CLK;

    secded_scrubber #(.ADDR_W(ADDR_W), .GAP(GAP)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .HOST_BUSY (HOST_BUSY),
        .MEM_RE    (MEM_RE),
        .MEM_WE    (MEM_WE),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_WDATA (MEM_WDATA),
        .MEM_RDATA (MEM_RDATA),
        .CE_CNT    (CE_CNT),
        .UE_CNT    (UE_CNT),
        .UE_FLAG   (UE_FLAG),
        .UE_ADDR   (UE_ADDR),
        .UE_CLR    (UE_CLR),
        .PASS_DONE (PASS_DONE)
    );

    // Memory model: image reloaded during reset, read data registered.
    always @(posedge CLK) begin
        if (RST) begin
            mem       <= image;
            MEM_RDATA <= '0;
        end else begin
            if (MEM_RE) MEM_RDATA <= mem[MEM_ADDR];
            if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
        end
    end

    always @(posedge CLK) cyc++;

    // Monitor on the falling edge: log strobes and protocol violations.
    always @(negedge CLK) begin
        if (MEM_RE) begin
            rdAddr.push_back(int'(MEM_ADDR));
            rdCyc.push_back(cyc);
        end
        if (MEM_WE) begin
            wrAddr.push_back(int'(MEM_ADDR));
            wrCyc.push_back(cyc);
            wrData.push_back(MEM_WDATA);
        end
        if (PASS_DONE) begin
            passCnt++;
            passAddr = int'(MEM_ADDR);
        end
        if ((MEM_RE && MEM_WE) || ((MEM_RE || MEM_WE) && (HOST_BUSY || RST))) badStrobe++;
        if (UE_FLAG) flagSeen++;
    end

    // Reference encoder: each check bit k is the XOR of all positions whose
    // index has bit k set; bit 0 makes the whole word even parity.
    function automatic logic [71:0] refEncode(input logic [63:0] data);
        logic [71:0] cw;
        logic        p;
        int          d;
        cw = '0;
        d  = 0;
        for (int pos = 1; pos < 72; pos++) begin
            if (!$onehot(pos)) begin
                cw[pos] = data[d];
                d++;
            end
        end
        for (int k = 0; k < 7; k++) begin
            p = 1'b0;
            for (int pos = 1; pos < 72; pos++) begin
                if (pos[k]) p = p ^ cw[pos];
            end
            cw[1 << k] = p;
        end
        cw[0] = ^cw[71:1];
        return cw;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic loadClean();
        for (int i = 0; i < DEPTH; i++) begin
            image[i] = refEncode({16'(i + 1), 48'h5A5A_0F0F_C3C3});
        end
    endtask

    task automatic applyReset();
        RST = 1'b1; EN = 1'b0; HOST_BUSY = 1'b0; UE_CLR = 1'b0;
        tick(2);
        rdAddr.delete(); rdCyc.delete(); wrAddr.delete(); wrCyc.delete(); wrData.delete();
        passCnt = 0; passAddr = -1; badStrobe = 0; flagSeen = 0;
    endtask

    task automatic startScrub();
        RST = 1'b0;
        EN  = 1'b1;
        t0  = cyc;
    endtask

    task automatic waitPass(input int target, output bit ok);
        int budget;
        budget = 300;
        while (passCnt < target && budget > 0) begin
            tick(1);
            budget--;
        end
        ok = (passCnt >= target);
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = 1'b1; HOST_BUSY = 1'b0; UE_CLR = 1'b0;
        loadClean();
        tick(3);
        checks++;
        if (MEM_RE !== 1'b0 || MEM_WE !== 1'b0 || PASS_DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: re=%b we=%b pass=%b required 0 0 0", MEM_RE, MEM_WE, PASS_DONE);
        end
        checks++;
        if (MEM_ADDR !== '0 || MEM_WDATA !== '0) begin
            errors++;
            $display("FAIL reset_addr_wdata: addr=%0d wdata=%h required 0 0", MEM_ADDR, MEM_WDATA);
        end
        checks++;
        if (CE_CNT !== 16'd0 || UE_CNT !== 16'd0 || UE_FLAG !== 1'b0 || UE_ADDR !== '0) begin
            errors++;
            $display("FAIL reset_status: ce=%0d ue=%0d flag=%b ueaddr=%0d required 0 0 0 0", CE_CNT, UE_CNT, UE_FLAG, UE_ADDR);
        end
        checks++;
        if (badStrobe !== 0) begin
            errors++;
            $display("FAIL reset_no_strobe: violations=%0d required 0", badStrobe);
        end
    endtask

    task automatic test_clean_pass();
        bit ok;
        loadClean();
        applyReset();
        startScrub();
        waitPass(1, ok);
        EN = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL clean_pass_timeout: passes=%0d required 1", passCnt);
        end
        checks++;
        if (rdAddr.size() !== 4 || wrAddr.size() !== 0) begin
            errors++;
            $display("FAIL clean_counts: reads=%0d writes=%0d required 4 0", rdAddr.size(), wrAddr.size());
        end
        for (int i = 0; i < rdAddr.size() && i < 4; i++) begin
            checks++;
            if (rdAddr[i] !== i || rdCyc[i] - t0 !== 3 + 5 * i) begin
                errors++;
                $display("FAIL clean_read%0d: addr=%0d cycle=%0d required %0d %0d", i, rdAddr[i], rdCyc[i] - t0, i, 3 + 5 * i);
            end
        end
        checks++;
        if (passAddr !== 3 || CE_CNT !== 16'd0 || UE_CNT !== 16'd0) begin
            errors++;
            $display("FAIL clean_pass_status: passaddr=%0d ce=%0d ue=%0d required 3 0 0", passAddr, CE_CNT, UE_CNT);
        end
    endtask

    task automatic test_single_error();
        bit ok;
        logic [71:0] clean;
        clean = refEncode(64'hDEAD_BEEF_CAFE_CAFE);
        loadClean();
        image[1] = clean ^ (72'd1 << 20);
        applyReset();
        startScrub();
        waitPass(1, ok);
        EN = 1'b0;
        checks++;
        if (!ok || wrAddr.size() !== 1) begin
            errors++;
            $display("FAIL single_writes: pass=%b writes=%0d required 1 1", ok, wrAddr.size());
        end else begin
            checks++;
            if (wrAddr[0] !== 1 || wrData[0] !== clean || wrCyc[0] - t0 !== 12) begin
                errors++;
                $display("FAIL single_writeback: addr=%0d cycle=%0d data=%h required 1 12 %h", wrAddr[0], wrCyc[0] - t0, wrData[0], clean);
            end
        end
        checks++;
        if (mem[1] !== clean || CE_CNT !== 16'd1 || UE_CNT !== 16'd0 || UE_FLAG !== 1'b0) begin
            errors++;
            $display("FAIL single_status: mem1=%h ce=%0d ue=%0d flag=%b required %h 1 0 0", mem[1], CE_CNT, UE_CNT, UE_FLAG, clean);
        end
    endtask

    task automatic test_double_error();
        bit ok;
        loadClean();
        image[2] = image[2] ^ (72'd1 << 52) ^ (72'd1 << 56);
        applyReset();
        startScrub();
        waitPass(1, ok);
        EN = 1'b0;
        tick(3);
        checks++;
        if (!ok || wrAddr.size() !== 0 || CE_CNT !== 16'd0) begin
            errors++;
            $display("FAIL double_no_write: pass=%b writes=%0d ce=%0d required 1 0 0", ok, wrAddr.size(), CE_CNT);
        end
        checks++;
        if (UE_CNT !== 16'd1 || UE_FLAG !== 1'b1 || UE_ADDR !== 2'd2) begin
            errors++;
            $display("FAIL double_log: ue=%0d flag=%b ueaddr=%0d required 1 1 2", UE_CNT, UE_FLAG, UE_ADDR);
        end
        UE_CLR = 1'b1;
        tick(1);
        UE_CLR = 1'b0;
        checks++;
        if (UE_FLAG !== 1'b0 || UE_CNT !== 16'd1 || UE_ADDR !== 2'd2) begin
            errors++;
            $display("FAIL double_clear: flag=%b ue=%0d ueaddr=%0d required 0 1 2", UE_FLAG, UE_CNT, UE_ADDR);
        end
        // Clear held through a whole pass: the new error must still show for one cycle.
        flagSeen = 0;
        UE_CLR   = 1'b1;
        EN       = 1'b1;
        waitPass(2, ok);
        EN     = 1'b0;
        UE_CLR = 1'b0;
        checks++;
        if (!ok || flagSeen !== 1 || UE_CNT !== 16'd2) begin
            errors++;
            $display("FAIL double_set_wins: pass=%b flagcycles=%0d ue=%0d required 1 1 2", ok, flagSeen, UE_CNT);
        end
    endtask

    task automatic test_host_busy();
        int budget, rel;
        logic [71:0] clean;
        clean = refEncode(64'hDEAD_BEEF_CAFE_CAFE);
        loadClean();
        image[1] = clean ^ (72'd1 << 20);
        applyReset();
        startScrub();
        budget = 300;
        while (passCnt < 1 && budget > 0) begin
            rel = cyc - t0;
            HOST_BUSY = ((rel >= 8 && rel <= 12) || (rel >= 17 && rel <= 21));
            tick(1);
            budget--;
        end
        HOST_BUSY = 1'b0;
        EN = 1'b0;
        checks++;
        if (rdAddr.size() !== 4 || wrAddr.size() !== 1) begin
            errors++;
            $display("FAIL busy_counts: reads=%0d writes=%0d required 4 1", rdAddr.size(), wrAddr.size());
        end else begin
            checks++;
            if (rdAddr[1] !== 1 || rdCyc[1] - t0 !== 13 || rdCyc[0] - t0 !== 3) begin
                errors++;
                $display("FAIL busy_read: addr=%0d cycle=%0d first=%0d required 1 13 3", rdAddr[1], rdCyc[1] - t0, rdCyc[0] - t0);
            end
            checks++;
            if (wrAddr[0] !== 1 || wrCyc[0] - t0 !== 22 || wrData[0] !== clean) begin
                errors++;
                $display("FAIL busy_write: addr=%0d cycle=%0d data=%h required 1 22 %h", wrAddr[0], wrCyc[0] - t0, wrData[0], clean);
            end
        end
        checks++;
        if (badStrobe !== 0) begin
            errors++;
            $display("FAIL busy_violation: violations=%0d required 0", badStrobe);
        end
    endtask

    task automatic test_en_drop();
        logic [71:0] clean;
        clean = refEncode(64'hDEAD_BEEF_CAFE_CAFE);
        loadClean();
        image[1] = clean ^ (72'd1 << 20);
        applyReset();
        startScrub();
        tick(9);
        EN = 1'b0;
        tick(20);
        checks++;
        if (rdAddr.size() !== 2 || wrAddr.size() !== 1 || passCnt !== 0) begin
            errors++;
            $display("FAIL en_drop_counts: reads=%0d writes=%0d passes=%0d required 2 1 0", rdAddr.size(), wrAddr.size(), passCnt);
        end
        checks++;
        if (mem[1] !== clean || CE_CNT !== 16'd1 || MEM_ADDR !== 2'd2) begin
            errors++;
            $display("FAIL en_drop_finish: mem1=%h ce=%0d addr=%0d required %h 1 2", mem[1], CE_CNT, MEM_ADDR, clean);
        end
    endtask

    task automatic test_reset_in_encode();
        bit ok;
        logic [71:0] clean;
        clean = refEncode(64'hDEAD_BEEF_CAFE_CAFE);
        loadClean();
        image[1] = clean ^ (72'd1 << 20);
        applyReset();
        startScrub();
        tick(11);
        checks++;
        if (CE_CNT !== 16'd1 || wrAddr.size() !== 0) begin
            errors++;
            $display("FAIL rst_enc_pre: ce=%0d writes=%0d required 1 0", CE_CNT, wrAddr.size());
        end
        RST = 1'b1;
        tick(1);
        checks++;
        if (MEM_RE !== 1'b0 || MEM_WE !== 1'b0 || MEM_WDATA !== '0 || MEM_ADDR !== '0 || PASS_DONE !== 1'b0) begin
            errors++;
            $display("FAIL rst_enc_port: re=%b we=%b wdata=%h addr=%0d pass=%b required all 0", MEM_RE, MEM_WE, MEM_WDATA, MEM_ADDR, PASS_DONE);
        end
        checks++;
        if (CE_CNT !== 16'd0 || UE_CNT !== 16'd0 || UE_FLAG !== 1'b0 || UE_ADDR !== '0) begin
            errors++;
            $display("FAIL rst_enc_status: ce=%0d ue=%0d flag=%b ueaddr=%0d required 0 0 0 0", CE_CNT, UE_CNT, UE_FLAG, UE_ADDR);
        end
        startScrub();
        waitPass(1, ok);
        EN = 1'b0;
        checks++;
        if (!ok || rdAddr.size() !== 6 || wrAddr.size() !== 1) begin
            errors++;
            $display("FAIL rst_enc_counts: pass=%b reads=%0d writes=%0d required 1 6 1", ok, rdAddr.size(), wrAddr.size());
        end else begin
            checks++;
            if (rdAddr[2] !== 0 || rdCyc[2] - t0 !== 3 || wrCyc[0] - t0 !== 12 || wrData[0] !== clean) begin
                errors++;
                $display("FAIL rst_enc_restart: addr=%0d rdcycle=%0d wrcycle=%0d required 0 3 12", rdAddr[2], rdCyc[2] - t0, wrCyc[0] - t0);
            end
        end
        checks++;
        if (badStrobe !== 0) begin
            errors++;
            $display("FAIL rst_enc_violation: violations=%0d required 0", badStrobe);
        end
    endtask

    initial begin
        $display("[TB] secded_scrubber directed bench start");
        test_reset();
        test_clean_pass();
        test_single_error();
        test_double_error();
        test_host_busy();
        test_en_drop();
        test_reset_in_encode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
